// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - regfile write-port arbiter between the writeback stage and an MDU result FIFO
// Optional pending-destination scoreboard on pend_mask: define ARB_SCOREBOARD_EN
module regfile_wb_arbiter #(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_data,
    output logic        pipe_stall_req,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_rd,
    input  logic [31:0] mdu_data,
    output logic        mdu_ready,
    output logic        rf_load,
    output logic [4:0]  rf_dest,
    output logic [31:0] rf_in,
    output logic        busy,
    output logic [31:0] pend_mask
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]    fifo_rd_q   [FIFO_DEPTH];
    logic [31:0]   fifo_data_q [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          pipe_we_eff, push, pop;
    logic [4:0]    head_rd;
    logic [31:0]   head_data;

    assign pipe_we_eff = pipe_we && (pipe_rd != 5'd0);
    assign head_rd     = fifo_rd_q[rd_ptr_q];
    assign head_data   = fifo_data_q[rd_ptr_q];
    assign busy        = (count_q != '0);
    assign mdu_ready   = (count_q < CW'(FIFO_DEPTH));
    assign push        = mdu_valid && mdu_ready;

    // Outputs are gated while reset is held so no write escapes during an async reset.
    always_comb begin
        pop            = 1'b0;
        pipe_stall_req = 1'b0;
        rf_load        = 1'b0;
        rf_dest        = 5'd0;
        rf_in          = 32'd0;
        starve_d       = '0;
        if (!rst) begin
            starve_d = '0;
        end else if (pipe_we_eff && (starve_q < SW'(STARVE_LIMIT))) begin
            rf_load  = 1'b1;
            rf_dest  = pipe_rd;
            rf_in    = pipe_data;
            starve_d = busy ? starve_q + SW'(1) : '0;
        end else if (pipe_we_eff || busy) begin
            // Forced drain when pipe_we_eff, plain drain otherwise; rd=0 entries pop silently.
            pop            = 1'b1;
            pipe_stall_req = pipe_we_eff;
            rf_load        = (head_rd != 5'd0);
            rf_dest        = head_rd;
            rf_in          = (head_rd != 5'd0) ? head_data : 32'd0;
        end
    end

    always_comb begin
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_rd_q[i]   <= 5'd0;
                fifo_data_q[i] <= 32'd0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            if (push) begin
                fifo_rd_q[wr_ptr_q]   <= mdu_rd;
                fifo_data_q[wr_ptr_q] <= mdu_data;
            end
        end
    end

`ifdef ARB_SCOREBOARD_EN
    logic [31:0] pend_mask_c;

    always_comb begin
        pend_mask_c = 32'd0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (CW'(i) < count_q) begin
                pend_mask_c[fifo_rd_q[rd_ptr_q + PW'(i)]] = 1'b1;
            end
        end
        pend_mask_c[0] = 1'b0;
    end

    assign pend_mask = pend_mask_c;
`else
    assign pend_mask = 32'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed-vector bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        pipe_stall_req;
    logic        mdu_valid;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_data;
    logic        mdu_ready;
    logic        rf_load;
    logic [4:0]  rf_dest;
    logic [31:0] rf_in;
    logic        busy;
    logic [31:0] pend_mask;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [38:0] obs;
    logic [38:0] exp_v;

`ifdef ARB_SCOREBOARD_EN
    localparam logic [31:0] PM_9    = 32'h0000_0200;
    localparam logic [31:0] PM_9_12 = 32'h0000_1200;
    localparam logic [31:0] PM_12   = 32'h0000_1000;
`else
    localparam logic [31:0] PM_9    = 32'h0;
    localparam logic [31:0] PM_9_12 = 32'h0;
    localparam logic [31:0] PM_12   = 32'h0;
`endif

    assign obs = {pipe_stall_req, rf_load, rf_dest, rf_in};

    regfile_wb_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
        .pipe_stall_req(pipe_stall_req),
        .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
        .rf_load(rf_load), .rf_dest(rf_dest), .rf_in(rf_in),
        .busy(busy), .pend_mask(pend_mask)
    );

    always #5 clk = ~clk;

    task automatic test_reset;
        #1;
        vec_cnt++;
        if ({obs, busy, mdu_ready, pend_mask} !== {39'd0, 1'b0, 1'b1, 32'd0}) begin
            err_cnt++;
            $display("FAIL reset_state got obs=%h busy=%b rdy=%b pm=%h exp obs=0 busy=0 rdy=1 pm=0", obs, busy, mdu_ready, pend_mask);
        end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); #1;
        vec_cnt++;
        if ({obs, busy, mdu_ready} !== {39'd0, 1'b0, 1'b1}) begin
            err_cnt++;
            $display("FAIL reset_release got obs=%h busy=%b rdy=%b exp obs=0 busy=0 rdy=1", obs, busy, mdu_ready);
        end
    endtask

    task automatic test_mdu_basic;
        @(negedge clk); mdu_valid = 1'b1; mdu_rd = 5'd5; mdu_data = 32'h1234; #1;
        vec_cnt++;
        if ({obs, mdu_ready} !== {39'd0, 1'b1}) begin
            err_cnt++;
            $display("FAIL basic_push got obs=%h rdy=%b exp obs=0 rdy=1", obs, mdu_ready);
        end
        @(negedge clk); mdu_valid = 1'b0; #1;
        exp_v = {1'b0, 1'b1, 5'd5, 32'h1234};
        vec_cnt++;
        if ({obs, busy} !== {exp_v, 1'b1}) begin
            err_cnt++;
            $display("FAIL basic_write got obs=%h busy=%b exp obs=%h busy=1", obs, busy, exp_v);
        end
        @(negedge clk); #1;
        vec_cnt++;
        if ({obs, busy} !== {39'd0, 1'b0}) begin
            err_cnt++;
            $display("FAIL basic_drained got obs=%h busy=%b exp obs=0 busy=0", obs, busy);
        end
    endtask

    task automatic test_starvation;
        @(negedge clk);
        pipe_we = 1'b1; pipe_rd = 5'd3; pipe_data = 32'hA0;
        mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 32'h77; #1;
        exp_v = {1'b0, 1'b1, 5'd3, 32'hA0};
        vec_cnt++;
        if (obs !== exp_v) begin
            err_cnt++;
            $display("FAIL starve_c0 got %h exp %h", obs, exp_v);
        end
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk); mdu_valid = 1'b0; pipe_data = 32'hA0 + c; #1;
            exp_v = {1'b0, 1'b1, 5'd3, 32'hA0 + c};
            vec_cnt++;
            if (obs !== exp_v) begin
                err_cnt++;
                $display("FAIL starve_grant%0d got %h exp %h", c, obs, exp_v);
            end
        end
        @(negedge clk); pipe_data = 32'hA5; #1;
        exp_v = {1'b1, 1'b1, 5'd7, 32'h77};
        vec_cnt++;
        if ({obs, busy} !== {exp_v, 1'b1}) begin
            err_cnt++;
            $display("FAIL starve_forced got obs=%h busy=%b exp obs=%h busy=1", obs, busy, exp_v);
        end
        @(negedge clk); #1;
        exp_v = {1'b0, 1'b1, 5'd3, 32'hA5};
        vec_cnt++;
        if ({obs, busy} !== {exp_v, 1'b0}) begin
            err_cnt++;
            $display("FAIL starve_retry got obs=%h busy=%b exp obs=%h busy=0", obs, busy, exp_v);
        end
        @(negedge clk); pipe_we = 1'b0;
    endtask

    task automatic test_back_to_back;
        pipe_we = 1'b1; pipe_rd = 5'd3; pipe_data = 32'h300;
        mdu_valid = 1'b1; mdu_rd = 5'd10; mdu_data = 32'hA; #1;
        exp_v = {1'b0, 1'b1, 5'd3, 32'h300};
        vec_cnt++;
        if (obs !== exp_v) begin
            err_cnt++;
            $display("FAIL b2b_c0 got %h exp %h", obs, exp_v);
        end
        @(negedge clk); mdu_rd = 5'd11; mdu_data = 32'hB; #1;
        vec_cnt++;
        if ({obs, mdu_ready} !== {exp_v, 1'b1}) begin
            err_cnt++;
            $display("FAIL b2b_c1 got obs=%h rdy=%b exp obs=%h rdy=1", obs, mdu_ready, exp_v);
        end
        @(negedge clk); mdu_rd = 5'd12; mdu_data = 32'hC; #1;
        vec_cnt++;
        if ({obs, mdu_ready} !== {exp_v, 1'b0}) begin
            err_cnt++;
            $display("FAIL b2b_full got obs=%h rdy=%b exp obs=%h rdy=0", obs, mdu_ready, exp_v);
        end
        @(negedge clk); pipe_we = 1'b0; #1;
        exp_v = {1'b0, 1'b1, 5'd10, 32'hA};
        vec_cnt++;
        if ({obs, mdu_ready} !== {exp_v, 1'b0}) begin
            err_cnt++;
            $display("FAIL b2b_popA got obs=%h rdy=%b exp obs=%h rdy=0", obs, mdu_ready, exp_v);
        end
        @(negedge clk); #1;
        exp_v = {1'b0, 1'b1, 5'd11, 32'hB};
        vec_cnt++;
        if ({obs, mdu_ready} !== {exp_v, 1'b1}) begin
            err_cnt++;
            $display("FAIL b2b_popB got obs=%h rdy=%b exp obs=%h rdy=1", obs, mdu_ready, exp_v);
        end
        @(negedge clk); mdu_valid = 1'b0; #1;
        exp_v = {1'b0, 1'b1, 5'd12, 32'hC};
        vec_cnt++;
        if (obs !== exp_v) begin
            err_cnt++;
            $display("FAIL b2b_popC got %h exp %h", obs, exp_v);
        end
        @(negedge clk); #1;
        vec_cnt++;
        if ({obs, busy} !== {39'd0, 1'b0}) begin
            err_cnt++;
            $display("FAIL b2b_idle got obs=%h busy=%b exp obs=0 busy=0", obs, busy);
        end
    endtask

    task automatic test_zero_rd;
        @(negedge clk);
        pipe_we = 1'b1; pipe_rd = 5'd0; pipe_data = 32'hBEEF;
        mdu_valid = 1'b1; mdu_rd = 5'd0; mdu_data = 32'hDEAD; #1;
        vec_cnt++;
        if (obs !== 39'd0) begin
            err_cnt++;
            $display("FAIL zero_push got %h exp 0", obs);
        end
        @(negedge clk); mdu_valid = 1'b0; #1;
        vec_cnt++;
        if ({obs, busy} !== {39'd0, 1'b1}) begin
            err_cnt++;
            $display("FAIL zero_pop got obs=%h busy=%b exp obs=0 busy=1", obs, busy);
        end
        @(negedge clk); #1;
        vec_cnt++;
        if ({obs, busy} !== {39'd0, 1'b0}) begin
            err_cnt++;
            $display("FAIL zero_drained got obs=%h busy=%b exp obs=0 busy=0", obs, busy);
        end
        pipe_we = 1'b0;
    endtask

    task automatic test_scoreboard;
        @(negedge clk);
        pipe_we = 1'b1; pipe_rd = 5'd3; pipe_data = 32'h33;
        mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_data = 32'h9; #1;
        vec_cnt++;
        if (pend_mask !== 32'd0) begin
            err_cnt++;
            $display("FAIL sb_empty got %h exp 0", pend_mask);
        end
        @(negedge clk); mdu_rd = 5'd12; mdu_data = 32'h12; #1;
        vec_cnt++;
        if (pend_mask !== PM_9) begin
            err_cnt++;
            $display("FAIL sb_one got %h exp %h", pend_mask, PM_9);
        end
        @(negedge clk); mdu_valid = 1'b0; #1;
        vec_cnt++;
        if (pend_mask !== PM_9_12) begin
            err_cnt++;
            $display("FAIL sb_two got %h exp %h", pend_mask, PM_9_12);
        end
        @(negedge clk); pipe_we = 1'b0; #1;
        exp_v = {1'b0, 1'b1, 5'd9, 32'h9};
        vec_cnt++;
        if ({obs, pend_mask} !== {exp_v, PM_9_12}) begin
            err_cnt++;
            $display("FAIL sb_pop9 got obs=%h pm=%h exp obs=%h pm=%h", obs, pend_mask, exp_v, PM_9_12);
        end
        @(negedge clk); #1;
        exp_v = {1'b0, 1'b1, 5'd12, 32'h12};
        vec_cnt++;
        if ({obs, pend_mask} !== {exp_v, PM_12}) begin
            err_cnt++;
            $display("FAIL sb_pop12 got obs=%h pm=%h exp obs=%h pm=%h", obs, pend_mask, exp_v, PM_12);
        end
        @(negedge clk); #1;
        vec_cnt++;
        if ({pend_mask, busy} !== {32'd0, 1'b0}) begin
            err_cnt++;
            $display("FAIL sb_clear got pm=%h busy=%b exp pm=0 busy=0", pend_mask, busy);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        pipe_we = 1'b1; pipe_rd = 5'd3; pipe_data = 32'h3;
        mdu_valid = 1'b1; mdu_rd = 5'd20; mdu_data = 32'h20;
        @(negedge clk); mdu_rd = 5'd21; mdu_data = 32'h21;
        @(negedge clk); mdu_valid = 1'b0; #1;
        vec_cnt++;
        if ({busy, mdu_ready} !== 2'b10) begin
            err_cnt++;
            $display("FAIL rmid_full got busy=%b rdy=%b exp busy=1 rdy=0", busy, mdu_ready);
        end
        #2; rst = 1'b0; #1;
        vec_cnt++;
        if ({obs, busy, mdu_ready, pend_mask} !== {39'd0, 1'b0, 1'b1, 32'd0}) begin
            err_cnt++;
            $display("FAIL rmid_async got obs=%h busy=%b rdy=%b pm=%h exp obs=0 busy=0 rdy=1 pm=0", obs, busy, mdu_ready, pend_mask);
        end
        @(negedge clk); pipe_we = 1'b0; rst = 1'b1;
        @(negedge clk); #1;
        vec_cnt++;
        if ({obs, busy} !== {39'd0, 1'b0}) begin
            err_cnt++;
            $display("FAIL rmid_discard got obs=%h busy=%b exp obs=0 busy=0", obs, busy);
        end
    endtask

    initial begin
        rst = 1'b0;
        pipe_we = 1'b0; pipe_rd = 5'd0; pipe_data = 32'd0;
        mdu_valid = 1'b0; mdu_rd = 5'd0; mdu_data = 32'd0;
        test_reset;
        test_mdu_basic;
        test_starvation;
        test_back_to_back;
        test_zero_rd;
        test_scoreboard;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
